// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the two-master memory arbiter.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } arb_state_t;

  typedef logic req_id_t;

  localparam req_id_t REQ_CORE = 1'b0;
  localparam req_id_t REQ_AUX  = 1'b1;

  localparam int unsigned DATA_W  = 32;
  localparam int unsigned FUNC3_W = 3;

endpackage

// File: rtl/mem_arbiter_rr_picker.sv
// Combinational round-robin winner select between two requesters.
module rr_picker
  import mem_arb_pkg::*;
(
  input  logic req_0,
  input  logic req_1,
  input  logic prio,
  output logic any_req,
  output logic winner
);

  // A lone requester wins outright; on a tie the pointer decides.
  always_comb begin
    any_req = req_0 | req_1;
    winner  = REQ_CORE;
    if (req_0 && req_1) begin
      winner = prio;
    end else if (req_1) begin
      winner = REQ_AUX;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Shares one single-ported memory between the core and a loader/debug master.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned ADDR_W       = 32,
  parameter int unsigned READ_LATENCY = 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                req_0,
  input  logic                wen_0,
  input  logic [ADDR_W-1:0]   addr_0,
  input  logic [DATA_W-1:0]   wd_0,
  input  logic [FUNC3_W-1:0]  func3_0,
  input  logic                req_1,
  input  logic                wen_1,
  input  logic [ADDR_W-1:0]   addr_1,
  input  logic [DATA_W-1:0]   wd_1,
  input  logic [FUNC3_W-1:0]  func3_1,
  output logic                gnt_0,
  output logic                gnt_1,
  output logic                resp_valid_0,
  output logic                resp_valid_1,
  output logic [DATA_W-1:0]   rdata,
  output logic                mem_wen,
  output logic [ADDR_W-1:0]   mem_ra,
  output logic [ADDR_W-1:0]   mem_wa,
  output logic [DATA_W-1:0]   mem_wd,
  output logic [FUNC3_W-1:0]  mem_func3,
  input  logic [DATA_W-1:0]   mem_rd
);

  localparam int unsigned CNT_W = $clog2(READ_LATENCY + 1);

  arb_state_t          state_q, state_d;
  logic                prio_q, prio_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                wen_q, wen_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wd_q, wd_d;
  logic [FUNC3_W-1:0]  func3_q, func3_d;
  logic                owner_q, owner_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;
  logic                mem_wen_q, mem_wen_d;
  logic [1:0]          resp_valid_q, resp_valid_d;

  logic any_req;
  logic winner;

  rr_picker u_picker (
    .req_0   (req_0),
    .req_1   (req_1),
    .prio    (prio_q),
    .any_req (any_req),
    .winner  (winner)
  );

  // State and datapath registers; reset drops any in-flight transaction.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      prio_q       <= 1'b0;
      cnt_q        <= '0;
      wen_q        <= 1'b0;
      addr_q       <= '0;
      wd_q         <= '0;
      func3_q      <= '0;
      owner_q      <= REQ_CORE;
      rdata_q      <= '0;
      mem_wen_q    <= 1'b0;
      resp_valid_q <= '0;
    end else begin
      state_q      <= state_d;
      prio_q       <= prio_d;
      cnt_q        <= cnt_d;
      wen_q        <= wen_d;
      addr_q       <= addr_d;
      wd_q         <= wd_d;
      func3_q      <= func3_d;
      owner_q      <= owner_d;
      rdata_q      <= rdata_d;
      mem_wen_q    <= mem_wen_d;
      resp_valid_q <= resp_valid_d;
    end
  end

  // Next-state, grant and registered-output decode. mem_wen and resp_valid
  // are computed one cycle early so they are flop outputs in ISSUE / RESP.
  always_comb begin
    state_d      = state_q;
    prio_d       = prio_q;
    cnt_d        = cnt_q;
    wen_d        = wen_q;
    addr_d       = addr_q;
    wd_d         = wd_q;
    func3_d      = func3_q;
    owner_d      = owner_q;
    rdata_d      = rdata_q;
    mem_wen_d    = 1'b0;
    resp_valid_d = '0;
    gnt_0        = 1'b0;
    gnt_1        = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (any_req) begin
          gnt_0   = (winner == REQ_CORE);
          gnt_1   = (winner == REQ_AUX);
          owner_d = winner;
          prio_d  = ~winner;
          if (winner == REQ_AUX) begin
            wen_d   = wen_1;
            addr_d  = addr_1;
            wd_d    = wd_1;
            func3_d = func3_1;
          end else begin
            wen_d   = wen_0;
            addr_d  = addr_0;
            wd_d    = wd_0;
            func3_d = func3_0;
          end
          mem_wen_d = wen_d;
          state_d   = ISSUE;
        end
      end
      ISSUE: begin
        if (wen_q) begin
          resp_valid_d[owner_q] = 1'b1;
          state_d               = RESP;
        end else begin
          cnt_d   = CNT_W'(READ_LATENCY - 1);
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (cnt_q == '0) begin
          rdata_d               = mem_rd;
          resp_valid_d[owner_q] = 1'b1;
          state_d               = RESP;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Memory port and response outputs come straight from flops; the address
  // therefore holds its last latched value outside ISSUE/WAIT.
  assign mem_wen      = mem_wen_q;
  assign mem_ra       = addr_q;
  assign mem_wa       = addr_q;
  assign mem_wd       = wd_q;
  assign mem_func3    = func3_q;
  assign resp_valid_0 = resp_valid_q[0];
  assign resp_valid_1 = resp_valid_q[1];
  assign rdata        = rdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter with a fixed-latency memory model.
module tb_mem_arbiter;
  import mem_arb_pkg::*;

  localparam int unsigned LAT = 2;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_0, wen_0, req_1, wen_1;
  logic [31:0] addr_0, wd_0, addr_1, wd_1;
  logic [2:0]  func3_0, func3_1;
  logic        gnt_0, gnt_1, resp_valid_0, resp_valid_1;
  logic [31:0] rdata, mem_ra, mem_wa, mem_wd, mem_rd;
  logic        mem_wen;
  logic [2:0]  mem_func3;

  int unsigned cyc = 0;
  int unsigned checks = 0;
  int unsigned failures = 0;

  typedef struct {
    int unsigned cyc;
    logic        owner;
    logic        rd;
    logic [31:0] data;
  } resp_t;

  typedef struct {
    int unsigned cyc;
    logic        wen;
    logic [31:0] addr;
    logic [31:0] wd;
    logic [2:0]  f3;
  } iss_t;

  resp_t resp_q[$];
  iss_t  iss_q[$];
  logic  gorder[$];

  logic        watch_on = 1'b0;
  logic [31:0] watch_addr = '0;

  mem_arbiter #(.ADDR_W(32), .READ_LATENCY(LAT)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_0(req_0), .wen_0(wen_0), .addr_0(addr_0), .wd_0(wd_0), .func3_0(func3_0),
    .req_1(req_1), .wen_1(wen_1), .addr_1(addr_1), .wd_1(wd_1), .func3_1(func3_1),
    .gnt_0(gnt_0), .gnt_1(gnt_1),
    .resp_valid_0(resp_valid_0), .resp_valid_1(resp_valid_1),
    .rdata(rdata), .mem_wen(mem_wen), .mem_ra(mem_ra), .mem_wa(mem_wa),
    .mem_wd(mem_wd), .mem_func3(mem_func3), .mem_rd(mem_rd)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Memory model: data appears LAT cycles after the address is presented.
  logic [31:0] ra_pipe [LAT];
  initial for (int i = 0; i < LAT; i++) ra_pipe[i] = '0;
  always @(posedge clk) begin
    ra_pipe[0] <= mem_ra;
    for (int i = 1; i < LAT; i++) ra_pipe[i] <= ra_pipe[i-1];
  end

  function automatic logic [31:0] mem_fn(input logic [31:0] a);
    if (a == 32'h80) return 32'h1234_5678;
    return {a[15:0], 16'hC0DE};
  endfunction
  assign mem_rd = mem_fn(ra_pipe[LAT-1]);

  task automatic check_eq(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: compares memory-port issues and responses against the queues.
  always @(negedge clk) begin
    iss_t  s;
    resp_t e;
    if (rst_n) begin
      if (gnt_0 || gnt_1) begin
        check_eq("gnt_onehot", 32'(gnt_0 & gnt_1), 32'd0);
        check_eq("gnt_only_idle", 32'(dut.state_q), 32'(IDLE));
      end
      if (watch_on) check_eq("late_addr_leak", 32'(mem_ra == watch_addr), 32'd0);

      if (iss_q.size() > 0 && iss_q[0].cyc <= cyc) begin
        s = iss_q.pop_front();
        check_eq("issue_cycle", cyc, s.cyc);
        check_eq("mem_wen", 32'(mem_wen), 32'(s.wen));
        check_eq("mem_ra", mem_ra, s.addr);
        check_eq("mem_wa", mem_wa, s.addr);
        check_eq("mem_func3", 32'(mem_func3), 32'(s.f3));
        if (s.wen) check_eq("mem_wd", mem_wd, s.wd);
      end else if (mem_wen) begin
        check_eq("spurious_wen", 32'(mem_wen), 32'd0);
      end

      if (resp_valid_0 || resp_valid_1) begin
        if (resp_q.size() == 0) begin
          check_eq("spurious_resp", {30'b0, resp_valid_1, resp_valid_0}, 32'd0);
        end else begin
          e = resp_q.pop_front();
          check_eq("resp_owner", {30'b0, resp_valid_1, resp_valid_0}, e.owner ? 32'd2 : 32'd1);
          check_eq("resp_cycle", cyc, e.cyc);
          if (e.rd) check_eq("rdata", rdata, e.data);
        end
      end else if (resp_q.size() > 0 && resp_q[0].cyc <= cyc) begin
        e = resp_q.pop_front();
        check_eq("resp_missing", 32'd0, 32'd1);
      end
    end
  end

  // Issue one request from requester k and wait (bounded) for its grant.
  task automatic do_req(input bit k, input bit wen, input logic [31:0] addr,
                        input logic [31:0] wd, input logic [2:0] f3,
                        input logic [31:0] exp_rd, input bit hold,
                        output int unsigned gcyc);
    bit got;
    got  = 1'b0;
    gcyc = 0;
    if (k) begin
      req_1 = 1'b1; wen_1 = wen; addr_1 = addr; wd_1 = wd; func3_1 = f3;
    end else begin
      req_0 = 1'b1; wen_0 = wen; addr_0 = addr; wd_0 = wd; func3_0 = f3;
    end
    for (int i = 0; i < 40 && !got; i++) begin
      @(negedge clk);
      if (rst_n && (k ? gnt_1 : gnt_0)) got = 1'b1;
    end
    if (!got) begin
      check_eq(k ? "gnt_1_timeout" : "gnt_0_timeout", 32'(got), 32'd1);
    end else begin
      gcyc = cyc;
      gorder.push_back(k);
      iss_q.push_back('{cyc: cyc + 1, wen: wen, addr: addr, wd: wd, f3: f3});
      resp_q.push_back('{cyc: wen ? cyc + 2 : cyc + LAT + 2, owner: k, rd: !wen, data: exp_rd});
      @(posedge clk);
      #1;
    end
    // Scramble fields after the grant; they must not be re-sampled.
    if (k) begin
      req_1 = hold; addr_1 = ~addr; wd_1 = ~wd; func3_1 = ~f3;
    end else begin
      req_0 = hold; addr_0 = ~addr; wd_0 = ~wd; func3_0 = ~f3;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int unsigned g0, g1, ga, gb;
    rst_n = 1'b0;
    req_0 = 0; wen_0 = 0; addr_0 = 0; wd_0 = 0; func3_0 = 0;
    req_1 = 0; wen_1 = 0; addr_1 = 0; wd_1 = 0; func3_1 = 0;

    // Reset values.
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_state", 32'(dut.state_q), 32'(IDLE));
    check_eq("rst_prio", 32'(dut.prio_q), 32'd0);
    check_eq("rst_mem_wen", 32'(mem_wen), 32'd0);
    check_eq("rst_mem_ra", mem_ra, 32'd0);
    check_eq("rst_mem_wd", mem_wd, 32'd0);
    check_eq("rst_func3", 32'(mem_func3), 32'd0);
    check_eq("rst_resp", {30'b0, resp_valid_1, resp_valid_0}, 32'd0);
    check_eq("rst_rdata", rdata, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Single write from the core.
    do_req(1'b0, 1'b1, 32'h40, 32'hDEAD_BEEF, 3'b010, 32'h0, 1'b0, g0);
    repeat (4) @(posedge clk); #1;

    // Read with latency 2 from the loader.
    do_req(1'b1, 1'b0, 32'h80, 32'h0, 3'b100, 32'h1234_5678, 1'b0, g1);
    repeat (6) @(posedge clk); #1;

    // Round-robin with both requesters holding reads.
    gorder.delete();
    fork
      begin
        do_req(1'b0, 1'b0, 32'h10, 32'h0, 3'b010, 32'h0010_C0DE, 1'b1, ga);
        do_req(1'b0, 1'b0, 32'h20, 32'h0, 3'b010, 32'h0020_C0DE, 1'b0, ga);
      end
      begin
        do_req(1'b1, 1'b0, 32'h30, 32'h0, 3'b010, 32'h0030_C0DE, 1'b1, gb);
        do_req(1'b1, 1'b0, 32'h40, 32'h0, 3'b010, 32'h0040_C0DE, 1'b0, gb);
      end
    join
    check_eq("rr_count", gorder.size(), 32'd4);
    if (gorder.size() == 4) begin
      check_eq("rr_grant0", 32'(gorder[0]), 32'd0);
      check_eq("rr_grant1", 32'(gorder[1]), 32'd1);
      check_eq("rr_grant2", 32'(gorder[2]), 32'd0);
      check_eq("rr_grant3", 32'(gorder[3]), 32'd1);
    end
    repeat (6) @(posedge clk); #1;

    // Late request raised while the core read is waiting.
    fork
      begin
        do_req(1'b0, 1'b0, 32'h100, 32'h0, 3'b001, 32'h0100_C0DE, 1'b0, g0);
      end
      begin
        for (int i = 0; i < 20 && dut.state_q != WAIT; i++) @(negedge clk);
        watch_addr = 32'h200;
        watch_on   = 1'b1;
        do_req(1'b1, 1'b0, 32'h200, 32'h0, 3'b101, 32'h0200_C0DE, 1'b0, g1);
        watch_on   = 1'b0;
      end
    join
    check_eq("late_gnt_cycle", g1, g0 + LAT + 3);
    repeat (6) @(posedge clk); #1;

    // Reset while a write is in ISSUE: mem_wen must drop at once.
    do_req(1'b0, 1'b1, 32'h50, 32'hCAFE_F00D, 3'b010, 32'h0, 1'b0, g0);
    check_eq("wen_before_rst", 32'(mem_wen), 32'd1);
    rst_n = 1'b0;
    #1;
    check_eq("wen_async_drop", 32'(mem_wen), 32'd0);
    iss_q.delete();
    resp_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Reset while a read is in WAIT.
    do_req(1'b1, 1'b0, 32'h300, 32'h0, 3'b010, 32'h0300_C0DE, 1'b0, g1);
    @(posedge clk); #1;
    check_eq("mid_state_wait", 32'(dut.state_q), 32'(WAIT));
    rst_n = 1'b0;
    #1;
    check_eq("mid_rst_wen", 32'(mem_wen), 32'd0);
    check_eq("mid_rst_resp", {30'b0, resp_valid_1, resp_valid_0}, 32'd0);
    check_eq("mid_rst_state", 32'(dut.state_q), 32'(IDLE));
    check_eq("mid_rst_prio", 32'(dut.prio_q), 32'd0);
    iss_q.delete();
    resp_q.delete();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // After reset, simultaneous requests grant the core first.
    fork
      do_req(1'b0, 1'b1, 32'h44, 32'h1111_1111, 3'b010, 32'h0, 1'b0, g0);
      do_req(1'b1, 1'b1, 32'h48, 32'h2222_2222, 3'b001, 32'h0, 1'b0, g1);
    join
    check_eq("post_rst_order", 32'(g1 > g0), 32'd1);
    check_eq("post_rst_gap", g1 - g0, 32'd3);

    repeat (10) @(posedge clk); #1;
    check_eq("iss_q_drained", iss_q.size(), 32'd0);
    check_eq("resp_q_drained", resp_q.size(), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
